// File: rtl/log2_iter_pkg.sv
// Shared types and width helpers for the iterative base-2 logarithm unit.
package log2_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int int_w(input int in_w);
    return $clog2(in_w);
  endfunction

  function automatic int out_w(input int in_w, input int frac_w);
    return $clog2(in_w) + frac_w;
  endfunction

endpackage

// File: rtl/log2_lod.sv
// Leading-one detector: index of the most significant set bit plus an all-zero flag.
module log2_lod #(
  parameter int W   = 16,
  parameter int K_W = 4
) (
  input  logic [W-1:0]   data,
  output logic [K_W-1:0] idx,
  output logic           zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    idx = {K_W{1'b0}};
    for (int i = 0; i < W; i++) begin
      if (data[i]) begin
        idx = K_W'(i);
      end else begin
        idx = idx;
      end
    end
    zero = (data == {W{1'b0}});
  end

endmodule

// File: rtl/log2_iter.sv
// Iterative log2: priority-encoded integer part, then one fraction bit per cycle by
// repeated squaring of the normalised mantissa.
module log2_iter
  import log2_iter_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int FRAC_W = 8,
  parameter int MAN_W  = 16,
  localparam int INT_W = int_w(IN_W),
  localparam int OUT_W = out_w(IN_W, FRAC_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  localparam int CNT_W = $clog2(FRAC_W + 1);

  if (IN_W < 2) begin : g_bad_in_w
    $error("log2_iter: IN_W must be at least 2");
  end
  if (FRAC_W < 1) begin : g_bad_frac_w
    $error("log2_iter: FRAC_W must be at least 1");
  end
  if (MAN_W < IN_W) begin : g_bad_man_w
    $error("log2_iter: MAN_W must be >= IN_W");
  end

  state_e             state_q, state_d;
  logic [IN_W-1:0]    data_q, data_d;
  logic [MAN_W-1:0]   m_q, m_d;
  logic [INT_W-1:0]   int_q, int_d;
  logic [FRAC_W-1:0]  frac_q, frac_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_q, zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_err_q, out_err_d;

  logic [INT_W-1:0]   lod_idx_s;
  logic               lod_zero_s;
  logic [INT_W-1:0]   shift_s;
  logic [MAN_W-1:0]   norm_m_s;
  logic [MAN_W:0]     p_top_s;
  logic               bit_s;

  log2_lod #(
    .W   (IN_W),
    .K_W (INT_W)
  ) u_lod (
    .data (data_q),
    .idx  (lod_idx_s),
    .zero (lod_zero_s)
  );

  // Normalisation and squaring datapath; p_top_s is p[2*MAN_W-1:MAN_W-1].
  always_comb begin
    shift_s  = INT_W'(IN_W - 1) - lod_idx_s;
    norm_m_s = MAN_W'(data_q << shift_s) << (MAN_W - IN_W);
    p_top_s  = (MAN_W + 1)'(({{MAN_W{1'b0}}, m_q} * {{MAN_W{1'b0}}, m_q}) >> (MAN_W - 1));
    bit_s    = p_top_s[MAN_W];
  end

  // Next-state and next-output logic; out_valid rises one cycle after DONE is entered.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    m_d         = m_q;
    int_d       = int_q;
    frac_d      = frac_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = NORM;
          data_d  = in_data;
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        frac_d = {FRAC_W{1'b0}};
        cnt_d  = {CNT_W{1'b0}};
        zero_d = lod_zero_s;
        if (lod_zero_s) begin
          int_d   = {INT_W{1'b0}};
          m_d     = {MAN_W{1'b0}};
          state_d = DONE;
        end else begin
          int_d   = lod_idx_s;
          m_d     = norm_m_s;
          state_d = ITER;
        end
      end
      ITER: begin
        frac_d = (frac_q << 1) | FRAC_W'(bit_s);
        cnt_d  = cnt_q + CNT_W'(1);
        if (bit_s) begin
          m_d = p_top_s[MAN_W:1];
        end else begin
          m_d = p_top_s[MAN_W-1:0];
        end
        if (cnt_q == CNT_W'(FRAC_W - 1)) begin
          state_d = DONE;
        end else begin
          state_d = ITER;
        end
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = {int_q, frac_q};
          out_err_d   = zero_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          out_data_d  = {OUT_W{1'b0}};
          out_err_d   = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      data_q      <= {IN_W{1'b0}};
      m_q         <= {MAN_W{1'b0}};
      int_q       <= {INT_W{1'b0}};
      frac_q      <= {FRAC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      m_q         <= m_d;
      int_q       <= int_d;
      frac_q      <= frac_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: doc/log2_iter.md
LOG2_ITER -- requirements
Module: log2_iter

Interface
REQ-001 The block SHALL have parameter IN_W, default 16: input operand width (unsigned integer), minimum 2.
REQ-002 The block SHALL have parameter FRAC_W, default 8: fractional bits of the result, minimum 1.
REQ-003 The block SHALL have parameter MAN_W, default 16: internal mantissa width; MAN_W >= IN_W enforced at elaboration.
REQ-004 The block SHALL have derived constant INT_W = clog2(IN_W) and OUT_W = INT_W + FRAC_W.
REQ-005 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 The block SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-007 The block SHALL have port in_valid  input  1  operand offered.
REQ-008 The block SHALL have port in_ready  output  1  block can accept an operand.
REQ-009 The block SHALL have port in_data  input  IN_W  unsigned operand.
REQ-010 The block SHALL have port out_valid  output  1  result available.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port out_data  output  OUT_W  result, unsigned fixed point: integer part [OUT_W-1:FRAC_W], fraction [FRAC_W-1:0].
REQ-013 The block SHALL have port out_err  output  1  operand was zero (log undefined); qualified by out_valid.

Function
REQ-014 The block SHALL use FSM states IDLE, NORM, ITER, DONE.
REQ-015 The block SHALL drive in_ready high only in IDLE; an operand is accepted on a clock edge with in_valid && in_ready, and in_data is registered at that edge.
REQ-016 In NORM, the integer part k SHALL be the index of the most significant set bit of the operand (priority encode).
REQ-017 In NORM, the mantissa m (MAN_W bits, format 1.(MAN_W-1)) SHALL be loaded with the operand shifted left by IN_W-1-k and zero-padded at the LSBs.
REQ-018 The block SHALL spend exactly FRAC_W cycles in ITER, producing one fraction bit per cycle, MSB first.
REQ-019 Each ITER cycle SHALL form p = m*m (2*MAN_W bits, format xx.(2*MAN_W-2)).
REQ-020 If p[2*MAN_W-1] is 1, the fraction bit SHALL be 1 and m SHALL load p[2*MAN_W-1:MAN_W]; otherwise the bit SHALL be 0 and m SHALL load p[2*MAN_W-2:MAN_W-1] (truncation, no rounding).
REQ-021 An iteration counter of clog2(FRAC_W+1) bits SHALL move the FSM from ITER to DONE after the FRAC_W-th bit.
REQ-022 For a nonzero operand, out_valid SHALL rise exactly FRAC_W+2 cycles after the accepting edge.
REQ-023 For a zero operand, NORM SHALL go directly to DONE with out_data = 0 and out_err = 1; out_valid rises 2 cycles after the accepting edge.
REQ-024 In DONE, out_valid, out_data and out_err SHALL be held stable until out_ready is sampled high; the FSM then returns to IDLE on that edge.
REQ-025 in_ready SHALL stay low for the whole of DONE, so no new operand is accepted until the result is consumed (no overlap).
REQ-026 in_data changes while the block is busy SHALL have no effect on the result in flight.
REQ-027 The outputs SHALL be fully registered, with no combinational path from in_* to out_*.

Reset
REQ-028 When reset_n is sampled low, the FSM SHALL go to IDLE and in_ready, out_valid, out_err and out_data SHALL be 0, with the mantissa, counter and accumulated fraction cleared.
REQ-029 Reset asserted mid-operation SHALL abandon the computation with no out_valid pulse; in the cycle after reset_n is released, in_ready = 1.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the helper functions for INT_W and OUT_W.
REQ-031 One sub-module, log2_lod, SHALL provide a parametrised leading-one detector returning the index k and a zero flag.

Verification
REQ-032 Defaults, in_data=1 -> out_data=0x000, out_err=0, out_valid at cycle 10.
REQ-033 Defaults, in_data=16 -> out_data=0x400.
REQ-034 Defaults, in_data=3 -> out_data=0x195, i.e. log2(3) ≈ 1.5820 after truncation.
REQ-035 Defaults, in_data=0xFFFF -> out_data=0xFFF; in_data=0 -> out_err=1, out_data=0, out_valid at cycle 2.
REQ-036 Hold out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, single transfer when out_ready rises; a second operand is accepted only after that transfer.
REQ-037 Pull reset_n low during ITER -> no out_valid; in_ready=1 the cycle after release; the next operand gives the correct result; a random sweep with IN_W=8 and FRAC_W=5 matches a bit-exact model.
